serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 SHALL provide port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port in_valid_i  input  1  operand set on a_i/b_i/carry_i is valid.
REQ-005 SHALL provide port in_ready_o  output  1  block can accept an operand set.
REQ-006 SHALL provide port a_i  input  WIDTH  operand A, unsigned.
REQ-007 SHALL provide port b_i  input  WIDTH  operand B, unsigned.
REQ-008 SHALL provide port carry_i  input  1  carry-in of the addition.
REQ-009 SHALL provide port out_valid_o  output  1  result on sum_o/carry_o is valid.
REQ-010 SHALL provide port out_ready_i  input  1  consumer accepts the result.
REQ-011 SHALL provide port sum_o  output  WIDTH  sum bits, a_i + b_i + carry_i modulo 2^WIDTH.
REQ-012 SHALL provide port carry_o  output  1  carry-out, bit WIDTH of a_i + b_i + carry_i.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: in_ready_o=1 and out_valid_o=0.
REQ-015 IDLE with in_valid_i=1 at an edge: SHALL capture a_i, b_i, carry_i into the A shift, B shift and carry registers, clear the bit counter, clear the sum register, then go to RUN.
REQ-016 IDLE with in_valid_i=0: SHALL stay in IDLE with all registers unchanged.
REQ-017 RUN: SHALL process exactly one bit per cycle, LSB first, using the full-adder cell.
  - s = A[0] ^ B[0] ^ c
  - c_next = majority(A[0], B[0], c)
REQ-018 RUN: SHALL per cycle shift s into sum register MSB with sum shifting right, shift A and B right by one, load c_next into the carry register, and increment the counter.
REQ-019 RUN: SHALL go to DONE on the edge processing bit WIDTH-1 (counter == WIDTH-1), so out_valid_o rises exactly WIDTH cycles after the accepting edge.
REQ-020 RUN and DONE: in_ready_o SHALL be 0, and in_valid_i and operand inputs SHALL be ignored.
REQ-021 DONE: out_valid_o=1; sum_o and carry_o SHALL equal the final sum register and carry register, held stable while out_ready_i=0 (unbounded backpressure).
REQ-022 DONE with out_ready_i=1 at an edge: SHALL complete the transfer and go to IDLE; out_valid_o deasserts the following cycle.
REQ-023 The block SHALL NOT accept a new operand set in the same cycle a result is transferred; minimum initiation interval is WIDTH+2 cycles.
REQ-024 sum_o and carry_o SHALL retain the last result in IDLE and change only during RUN.
REQ-025 WIDTH=1 SHALL work: RUN lasts one cycle.
REQ-026 The bit counter SHALL be sized to hold WIDTH-1 without overflow.
REQ-027 The result SHALL be bit-exact to {carry_o, sum_o} == a_i + b_i + carry_i at WIDTH+1 bits.

Reset
REQ-028 rst_i=1 at an edge SHALL force IDLE, out_valid_o=0, sum_o=0, carry_o=0, counter=0, and operand registers=0, regardless of state.
REQ-029 Reset SHALL take priority over in_valid_i and out_ready_i in the same cycle.
REQ-030 A reset in RUN or DONE SHALL abort the operation with no result presented.
REQ-031 in_ready_o SHALL be 0 while rst_i=1 and 1 from the first cycle after rst_i deasserts.

Verification (WIDTH=8 unless stated)
REQ-032 A bench SHALL cover: 0x00 + 0x00, carry_i=0 -> after 8 cycles out_valid_o=1, sum_o=0x00, carry_o=0.
REQ-033 A bench SHALL cover: 0xFF + 0x01, carry_i=0 -> sum_o=0x00, carry_o=1; and 0xA5 + 0x5A, carry_i=1 -> sum_o=0x00, carry_o=1.
REQ-034 A bench SHALL cover backpressure: 0x12 + 0x34, carry_i=0, out_ready_i=0 for 5 cycles.
  - sum_o=0x46, carry_o=0 held stable.
  - in_ready_o=0 throughout.
  - An in_valid_i pulse during that window is ignored.
  - Transfer on the first out_ready_i=1 edge.
REQ-035 A bench SHALL cover reset mid-RUN: rst_i=1 three cycles after accept -> next cycle IDLE, out_valid_o=0, sum_o=0x00, carry_o=0, in_ready_o=1 after release.
REQ-036 A bench SHALL cover back-to-back operations with out_ready_i=1 tied high: each result appears 8 cycles after its accept, and each accept is WIDTH+2=10 cycles apart.
REQ-037 A bench SHALL cover WIDTH=4 exhaustive: all 512 (a_i, b_i, carry_i) combinations -> {carry_o, sum_o} == a_i + b_i + carry_i.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// Signal names keep the block's _i/_o port naming, seen from the adder side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;

  // Adder side.
  modport slave (
    input  in_valid_i, a_i, b_i, carry_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, carry_o
  );

  // Producer/consumer side.
  modport master (
    output in_valid_i, a_i, b_i, carry_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, carry_o
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell reused WIDTH times, LSB first.
// Accepts one operand set, presents {carry_o, sum_o} until the consumer takes it.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  serial_adder_if.slave bus
);

  localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             step;
  logic             in_ready;
  logic             out_valid;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH:0]   sum_shift;

  // Full-adder cell on the current LSBs; the new sum bit enters at the MSB so
  // after WIDTH steps bit 0 of the result has walked down to sum_q[0].
  always_comb begin
    bit_s     = a_sh[0] ^ b_sh[0] ^ carry_q;
    bit_c     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
    sum_shift = {bit_s, sum_q} >> 1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst_i;
        accept   = bus.in_valid_i;
        if (bus.in_valid_i) state_next = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset; a reset in RUN/DONE must leave
  // zeros visible on sum_o/carry_o rather than a partial result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= bus.a_i;
      b_sh    <= bus.b_i;
      carry_q <= bus.carry_i;
      sum_q   <= '0;
      cnt     <= '0;
    end else if (step) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_q   <= sum_shift[WIDTH-1:0];
      carry_q <= bit_c;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Result registers double as the output; they hold through DONE and IDLE.
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed table and corner
// sequences, plus an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

  int n_vec = 0;
  int n_bad = 0;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];
  int         acc8[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;
    int         stall;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] pop8();
    logic [8:0] v;
    v = 9'h0;
    if (sb8.size() > 0) v = sb8.pop_front();
    return v;
  endfunction

  // One WIDTH=8 transaction with an optional consumer stall; an in_valid
  // pulse with different operands is injected during the stall window.
  task automatic run_op(input vec_t v, input string tag);
    int         acc;
    int         waited;
    logic [8:0] exp;
    @(negedge clk);
    check({tag, "_in_ready"}, bus8.in_ready_o, 1);
    bus8.a_i = v.a; bus8.b_i = v.b; bus8.carry_i = v.c; bus8.in_valid_i = 1'b1;
    sb8.push_back(v.exp);
    acc = cyc + 1;
    @(negedge clk);
    bus8.in_valid_i = 1'b0;
    bus8.a_i = ~v.a; bus8.b_i = ~v.b; bus8.carry_i = ~v.c;
    waited = 0;
    while (!bus8.out_valid_o && waited < 40) begin
      check({tag, "_busy_in_ready"}, bus8.in_ready_o, 0);
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, cyc - acc, 8);
    exp = pop8();
    for (int s = 0; s < v.stall; s++) begin
      check({tag, "_stall_valid"}, bus8.out_valid_o, 1);
      check({tag, "_stall_result"}, {bus8.carry_o, bus8.sum_o}, exp);
      check({tag, "_stall_in_ready"}, bus8.in_ready_o, 0);
      bus8.in_valid_i = (s == 2);
      bus8.a_i = 8'hEE; bus8.b_i = 8'h77; bus8.carry_i = 1'b1;
      @(negedge clk);
    end
    bus8.in_valid_i = 1'b0;
    check({tag, "_result"}, {bus8.carry_o, bus8.sum_o}, exp);
    bus8.out_ready_i = 1'b1;
    @(negedge clk);
    bus8.out_ready_i = 1'b0;
    check({tag, "_post_valid"}, bus8.out_valid_o, 0);
    check({tag, "_post_in_ready"}, bus8.in_ready_o, 1);
    check({tag, "_retained"}, {bus8.carry_o, bus8.sum_o}, exp);
  endtask

  initial begin
    int         done;
    int         ops;
    int         last_acc;
    int         idx;
    int         got;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] vi;
    logic [4:0] e4;

    bus8.in_valid_i = 1'b0; bus8.out_ready_i = 1'b0;
    bus8.a_i = '0; bus8.b_i = '0; bus8.carry_i = 1'b0;
    bus4.in_valid_i = 1'b0; bus4.out_ready_i = 1'b0;
    bus4.a_i = '0; bus4.b_i = '0; bus4.carry_i = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h000, 0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 0};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 9'h100, 0};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 9'h046, 5};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 9'h100, 0};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 9'h080, 2};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", bus8.in_ready_o, 0);
    check("rst_out_valid", bus8.out_valid_o, 0);
    check("rst_result", {bus8.carry_o, bus8.sum_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", bus8.in_ready_o, 1);
    check("rel_out_valid", bus8.out_valid_o, 0);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset three cycles after accept aborts the operation.
    @(negedge clk);
    check("abort_in_ready", bus8.in_ready_o, 1);
    bus8.a_i = 8'hFF; bus8.b_i = 8'hFF; bus8.carry_i = 1'b1; bus8.in_valid_i = 1'b1;
    sb8.push_back(9'h1FF);
    @(negedge clk);
    bus8.in_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", bus8.out_valid_o, 0);
    check("abort_result", {bus8.carry_o, bus8.sum_o}, 0);
    check("abort_in_ready_rst", bus8.in_ready_o, 0);
    rst = 1'b0;
    sb8.delete();
    @(negedge clk);
    check("abort_in_ready_rel", bus8.in_ready_o, 1);
    got = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus8.out_valid_o) got++;
    end
    check("abort_no_result", got, 0);

    // Back-to-back with out_ready tied high and in_valid held high.
    bus8.out_ready_i = 1'b1;
    done = 0; ops = 0; last_acc = 0;
    for (int t = 0; t < 200 && done < 4; t++) begin
      @(negedge clk);
      if (bus8.out_valid_o) begin
        check("b2b_result", {bus8.carry_o, bus8.sum_o}, pop8());
        check("b2b_latency", cyc - acc8.pop_front(), 8);
        done++;
      end
      if (bus8.in_ready_o && ops < 4) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        bus8.a_i = ra; bus8.b_i = rb; bus8.carry_i = rc; bus8.in_valid_i = 1'b1;
        sb8.push_back({1'b0, ra} + {1'b0, rb} + {8'h00, rc});
        if (ops > 0) check("b2b_interval", (cyc + 1) - last_acc, 10);
        last_acc = cyc + 1;
        acc8.push_back(cyc + 1);
        ops++;
      end else if (ops >= 4) begin
        bus8.in_valid_i = 1'b0;
      end
    end
    check("b2b_done", done, 4);
    bus8.in_valid_i = 1'b0;
    bus8.out_ready_i = 1'b0;

    // WIDTH=4 exhaustive sweep, streamed with consumer always ready.
    bus4.out_ready_i = 1'b1;
    idx = 0; got = 0;
    for (int t = 0; t < 6000 && got < 512; t++) begin
      @(negedge clk);
      if (bus4.out_valid_o) begin
        e4 = (sb4.size() > 0) ? sb4.pop_front() : 5'h0;
        check("w4_result", {bus4.carry_o, bus4.sum_o}, e4);
        got++;
      end
      if (bus4.in_ready_o && idx < 512) begin
        vi = idx[8:0];
        bus4.a_i = vi[8:5]; bus4.b_i = vi[4:1]; bus4.carry_i = vi[0];
        bus4.in_valid_i = 1'b1;
        sb4.push_back({1'b0, vi[8:5]} + {1'b0, vi[4:1]} + {4'h0, vi[0]});
        idx++;
      end else if (idx >= 512) begin
        bus4.in_valid_i = 1'b0;
      end
    end
    check("w4_count", got, 512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
